// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: heading, move pacing, step handshake, scoring
// Buttons are synchronised and edge-detected; moves are paced by a shrinking tick period.
module snake_game_ctrl #(
  parameter int TICK_DIV        = 30_000_000,
  parameter int SPEEDUP_STEP    = 2_000_000,
  parameter int MIN_TICK        = 5_000_000,
  parameter int FOODS_PER_LEVEL = 4,
  parameter int MAX_LEN         = 50,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_start,
  output logic               init_req,
  output logic               step_req,
  output logic [1:0]         step_dir,
  output logic               step_grow,
  input  logic               step_ack,
  input  logic               hit_wall,
  input  logic               hit_self,
  input  logic               food_hit,
  output logic               food_respawn,
  output logic [5:0]         length,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               playing,
  output logic               game_over
);

  localparam logic [1:0]  DIR_R = 2'd0;
  localparam logic [1:0]  DIR_U = 2'd1;
  localparam logic [1:0]  DIR_D = 2'd2;
  localparam logic [1:0]  DIR_L = 2'd3;
  localparam logic [24:0] TICK_P  = 25'(TICK_DIV);
  localparam logic [24:0] STEP_P  = 25'(SPEEDUP_STEP);
  localparam logic [24:0] MIN_P   = 25'(MIN_TICK);
  localparam logic [7:0]  FOOD_LAST = 8'(FOODS_PER_LEVEL - 1);
  localparam logic [5:0]  MAX_L   = 6'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, INIT, WAIT, STEP, EVAL, OVER} state_t;

  state_t      state;
  logic [4:0]  sync1, sync2, sync3, btn_edge;
  logic [1:0]  cur_dir, pend_dir, cand;
  logic [24:0] tick_cnt, period;
  logic [7:0]  food_cnt;
  logic        grow_pend, hit_l, food_l;
  logic        cand_valid, dir_ok, start_edge;

  // bit order: {start, right, left, down, up}; edge is registered so pin-to-edge is 3 clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      btn_edge <= '0;
    end else begin
      sync1    <= {btn_start, btn_right, btn_left, btn_down, btn_up};
      sync2    <= sync1;
      sync3    <= sync2;
      btn_edge <= sync2 & ~sync3;
    end
  end

  assign start_edge = btn_edge[4];

  // Priority pick first, then reject a reversal of the committed heading
  always_comb begin
    cand_valid = |btn_edge[3:0];
    cand       = DIR_R;
    if (btn_edge[0])      cand = DIR_U;
    else if (btn_edge[1]) cand = DIR_D;
    else if (btn_edge[2]) cand = DIR_L;
    dir_ok = cand_valid && (cand != (cur_dir ^ 2'b11));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      init_req     <= 1'b0;
      step_req     <= 1'b0;
      step_dir     <= DIR_R;
      step_grow    <= 1'b0;
      food_respawn <= 1'b0;
      length       <= 6'd1;
      score        <= '0;
      level        <= 4'd0;
      playing      <= 1'b0;
      game_over    <= 1'b0;
      cur_dir      <= DIR_R;
      pend_dir     <= DIR_R;
      tick_cnt     <= '0;
      period       <= TICK_P;
      grow_pend    <= 1'b0;
      food_cnt     <= 8'd0;
      hit_l        <= 1'b0;
      food_l       <= 1'b0;
    end else begin
      init_req     <= 1'b0;
      food_respawn <= 1'b0;
      if ((state inside {WAIT, STEP, EVAL}) && dir_ok) pend_dir <= cand;
      case (state)
        IDLE: if (start_edge) begin
          state    <= INIT;
          init_req <= 1'b1;
        end
        INIT: begin
          length    <= 6'd1;
          score     <= '0;
          level     <= 4'd0;
          food_cnt  <= 8'd0;
          grow_pend <= 1'b0;
          cur_dir   <= DIR_R;
          pend_dir  <= DIR_R;
          period    <= TICK_P;
          tick_cnt  <= '0;
          playing   <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (start_edge) begin
            state    <= INIT;
            init_req <= 1'b1;
            playing  <= 1'b0;
          end else if (tick_cnt == period - 25'd1) begin
            tick_cnt  <= '0;
            cur_dir   <= pend_dir;
            step_req  <= 1'b1;
            step_dir  <= pend_dir;
            step_grow <= grow_pend && (length < MAX_L);
            state     <= STEP;
          end else begin
            tick_cnt <= tick_cnt + 25'd1;
          end
        end
        // The handshake always completes; start is deliberately not looked at here
        STEP: if (step_ack) begin
          hit_l  <= hit_wall | hit_self;
          food_l <= food_hit;
          if (step_grow) begin
            length    <= length + 6'd1;
            grow_pend <= 1'b0;
          end
          step_req  <= 1'b0;
          step_grow <= 1'b0;
          state     <= EVAL;
        end
        EVAL: begin
          if (hit_l) begin
            state     <= OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            if (food_l) begin
              food_respawn <= 1'b1;
              grow_pend    <= 1'b1;
              if (score != '1) score <= score + 1'b1;
              if (food_cnt == FOOD_LAST) begin
                food_cnt <= 8'd0;
                if (level != 4'hF) level <= level + 4'd1;
                if (period >= STEP_P + MIN_P) period <= period - STEP_P;
                else period <= MIN_P;
              end else begin
                food_cnt <= food_cnt + 8'd1;
              end
            end
            state <= WAIT;
          end
        end
        OVER: if (start_edge) begin
          state     <= INIT;
          init_req  <= 1'b1;
          game_over <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed bench for snake_game_ctrl
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] btns;
  logic       init_req, step_req, step_grow, step_ack, hit_wall, hit_self, food_hit;
  logic [1:0] step_dir;
  logic       food_respawn, playing, game_over;
  logic [5:0] length;
  logic [7:0] score;
  logic [3:0] level;
  int         n_checks = 0;
  int         n_fail = 0;

  localparam logic [4:0] B_UP = 5'b00001, B_DOWN = 5'b00010, B_LEFT = 5'b00100,
                         B_RIGHT = 5'b01000, B_START = 5'b10000;
  localparam logic [25:0] RESET_VEC = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd1, 8'd0, 4'd0, 1'b0, 1'b0};

  snake_game_ctrl #(
    .TICK_DIV(10), .SPEEDUP_STEP(3), .MIN_TICK(4), .FOODS_PER_LEVEL(2), .MAX_LEN(50), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]), .btn_right(btns[3]), .btn_start(btns[4]),
    .init_req(init_req), .step_req(step_req), .step_dir(step_dir), .step_grow(step_grow),
    .step_ack(step_ack), .hit_wall(hit_wall), .hit_self(hit_self), .food_hit(food_hit),
    .food_respawn(food_respawn), .length(length), .score(score), .level(level),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] out_vec();
    return {init_req, step_req, step_dir, step_grow, food_respawn, length, score, level, playing, game_over};
  endfunction

  task automatic press_btns(input logic [4:0] m);
    @(negedge clk);
    btns = m;
    repeat (3) @(negedge clk);
    btns = 5'd0;
    repeat (3) @(negedge clk);
  endtask

  // Pulses start, counts init_req cycles and clocks from init_req falling to step_req
  task automatic press_start(output int init_cnt, output int to_step);
    int fall;
    init_cnt = 0; to_step = -1; fall = -1;
    @(negedge clk);
    btns = B_START;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 3) btns = 5'd0;
      if (init_req) init_cnt++;
      if (init_cnt > 0 && !init_req && fall < 0) fall = n;
      if (fall >= 0 && step_req) begin
        to_step = n - fall;
        break;
      end
    end
    btns = 5'd0;
  endtask

  // Acks the pending step, then waits for the next step_req (gap = -1 if none)
  task automatic ack_step(input logic food, input logic hself, input int limit,
                          output int gap, output int resp_at, output int resp_cnt);
    int n;
    resp_at = -1; resp_cnt = 0;
    step_ack = 1'b1; food_hit = food; hit_self = hself; hit_wall = 1'b0;
    @(negedge clk);
    step_ack = 1'b0; food_hit = 1'b0; hit_self = 1'b0;
    n = 1;
    while (n <= limit) begin
      if (food_respawn) begin
        resp_cnt++;
        if (resp_at < 0) resp_at = n;
      end
      if (step_req) break;
      @(negedge clk);
      n++;
    end
    gap = step_req ? n : -1;
  endtask

  task automatic test_reset();
    n_checks++; if (out_vec() !== RESET_VEC) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", out_vec(), RESET_VEC); end
  endtask

  task automatic test_start();
    int ic, ts;
    press_start(ic, ts);
    n_checks++; if (ic !== 1) begin n_fail++; $display("FAIL init_req_width: got %0d expected 1", ic); end
    n_checks++; if (ts !== 10) begin n_fail++; $display("FAIL first_step_delay: got %0d expected 10", ts); end
    n_checks++; if (step_dir !== 2'd0) begin n_fail++; $display("FAIL first_dir: got %0d expected 0", step_dir); end
    n_checks++; if (length !== 6'd1 || step_grow !== 1'b0) begin n_fail++; $display("FAIL first_len_grow: got %0d/%0d expected 1/0", length, step_grow); end
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL playing_high: got %0d expected 1", playing); end
  endtask

  task automatic test_heading();
    int g, ra, rc;
    press_btns(B_LEFT);
    ack_step(1'b0, 1'b0, 60, g, ra, rc);
    n_checks++; if (g !== 12) begin n_fail++; $display("FAIL step_gap_p10: got %0d expected 12", g); end
    n_checks++; if (step_dir !== 2'd0) begin n_fail++; $display("FAIL left_rejected: got %0d expected 0", step_dir); end
    press_btns(B_UP);
    ack_step(1'b0, 1'b0, 60, g, ra, rc);
    n_checks++; if (step_dir !== 2'd1) begin n_fail++; $display("FAIL up_accepted: got %0d expected 1", step_dir); end
    press_btns(B_DOWN);
    ack_step(1'b0, 1'b0, 60, g, ra, rc);
    n_checks++; if (step_dir !== 2'd1) begin n_fail++; $display("FAIL down_rejected: got %0d expected 1", step_dir); end
    press_btns(B_LEFT | B_RIGHT);
    ack_step(1'b0, 1'b0, 60, g, ra, rc);
    n_checks++; if (step_dir !== 2'd3) begin n_fail++; $display("FAIL left_over_right: got %0d expected 3", step_dir); end
    press_btns(B_UP);
    press_btns(B_DOWN);
    ack_step(1'b0, 1'b0, 60, g, ra, rc);
    n_checks++; if (step_dir !== 2'd2) begin n_fail++; $display("FAIL last_edge_wins: got %0d expected 2", step_dir); end
  endtask

  task automatic test_food();
    int g, ra, rc;
    ack_step(1'b1, 1'b0, 60, g, ra, rc);
    n_checks++; if (ra !== 2 || rc !== 1) begin n_fail++; $display("FAIL respawn_pulse: got at %0d x%0d expected at 2 x1", ra, rc); end
    n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL score_one: got %0d expected 1", score); end
    n_checks++; if (step_grow !== 1'b1) begin n_fail++; $display("FAIL grow_after_food: got %0d expected 1", step_grow); end
    ack_step(1'b0, 1'b0, 60, g, ra, rc);
    n_checks++; if (length !== 6'd2) begin n_fail++; $display("FAIL length_two: got %0d expected 2", length); end
    n_checks++; if (step_grow !== 1'b0 || rc !== 0) begin n_fail++; $display("FAIL grow_cleared: got %0d/%0d expected 0/0", step_grow, rc); end
  endtask

  task automatic test_levels();
    int g, ra, rc;
    int exp_gap[5] = '{9, 9, 6, 6, 6};
    logic [3:0] exp_lvl[5] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    for (int i = 0; i < 5; i++) begin
      ack_step(1'b1, 1'b0, 60, g, ra, rc);
      n_checks++; if (g !== exp_gap[i]) begin n_fail++; $display("FAIL level_gap_%0d: got %0d expected %0d", i, g, exp_gap[i]); end
      n_checks++; if (level !== exp_lvl[i]) begin n_fail++; $display("FAIL level_%0d: got %0d expected %0d", i, level, exp_lvl[i]); end
    end
    n_checks++; if (score !== 8'd6 || length !== 6'd6) begin n_fail++; $display("FAIL score_len_six: got %0d/%0d expected 6/6", score, length); end
  endtask

  task automatic test_game_over();
    int g, ra, rc, ic, ts;
    ack_step(1'b1, 1'b1, 40, g, ra, rc);
    n_checks++; if (g !== -1 || rc !== 0) begin n_fail++; $display("FAIL over_no_step: got gap %0d resp %0d expected -1/0", g, rc); end
    n_checks++; if (game_over !== 1'b1 || playing !== 1'b0) begin n_fail++; $display("FAIL over_flags: got %0d/%0d expected 1/0", game_over, playing); end
    n_checks++; if (score !== 8'd6 || level !== 4'd3) begin n_fail++; $display("FAIL over_frozen: got %0d/%0d expected 6/3", score, level); end
    press_start(ic, ts);
    n_checks++; if (ic !== 1 || ts !== 10) begin n_fail++; $display("FAIL restart: got init %0d delay %0d expected 1/10", ic, ts); end
    n_checks++; if (score !== 8'd0 || level !== 4'd0 || length !== 6'd1 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear: got %0d/%0d/%0d/%0d expected 0/0/1/0", score, level, length, game_over); end
  endtask

  task automatic test_stall_reset();
    int ic, ts;
    logic [1:0] d0;
    d0 = step_dir;
    press_start(ic, ts);
    n_checks++; if (ic !== 0 || step_req !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got init %0d req %0d expected 0/1", ic, step_req); end
    n_checks++; if (step_dir !== d0 || playing !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got dir %0d play %0d expected %0d/1", step_dir, playing, d0); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_vec() !== RESET_VEC) begin n_fail++; $display("FAIL async_reset: got %h expected %h", out_vec(), RESET_VEC); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; btns = 5'd0; step_ack = 1'b0; hit_wall = 1'b0; hit_self = 1'b0; food_hit = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_start();
    test_heading();
    test_food();
    test_levels();
    test_game_over();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
